// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Sequencing controller for a combinational ALU. It accepts one
// register-to-register instruction at a time over a valid/ready handshake.
// The instruction word is {cond, op, rd, rs1, rs2}. The controller issues
// registered operands and a control code to the ALU, then writes back the
// ALU result and holds the NZCV flags.
//
// Build option:
//   COND_EXEC_EN  defined   -> cond field gates writeback (00 AL, 01 EQ, 10 NE, 11 MI)
//                 undefined -> cond ignored, every instruction executes, res_skip stays 0
module alu_seq_ctrl #(
   parameter int W    = 4,
   parameter int NREG = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [10:0]   instr,
   input  logic          wr_en,
   input  logic [1:0]    wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [1:0]    rd_addr,
   output logic [W-1:0]  rd_data,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [2:0]    alu_cntl,
   input  logic [W-1:0]  alu_out,
   input  logic          alu_co,
   input  logic          alu_ovf,
   input  logic          alu_n,
   input  logic          alu_z,
   output logic          res_valid,
   output logic [W-1:0]  res_data,
   output logic          res_skip,
   output logic [3:0]    flags
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WB    = 2'b10
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic           accept_s;
   logic           host_wr_s;
   logic           wb_s;
   logic           cond_pass_s;

   logic [10:0]    instr_r;
   logic [W-1:0]   regs_r [NREG];
   logic [W-1:0]   alu_a_r;
   logic [W-1:0]   alu_b_r;
   logic [2:0]     alu_cntl_r;
   logic           res_valid_r;
   logic [W-1:0]   res_data_r;
   logic           res_skip_r;
   logic [3:0]     flags_r;
   logic           instr_ready_r;

   logic [2:0]     op_s;
   logic [1:0]     rd_s;
   logic [1:0]     rs1_s;
   logic [1:0]     rs2_s;

   assign op_s  = instr_r[8:6];
   assign rd_s  = instr_r[5:4];
   assign rs1_s = instr_r[3:2];
   assign rs2_s = instr_r[1:0];

`ifdef COND_EXEC_EN
   // Condition check against the architectural N and Z flags.
   function automatic logic cond_pass_f(input logic [1:0] cond, input logic n, input logic z);
      logic pass;
      case (cond)
         2'b00:   pass = 1'b1;
         2'b01:   pass = z;
         2'b10:   pass = ~z;
         2'b11:   pass = n;
         default: pass = 1'b1;
      endcase
      return pass;
   endfunction

   assign cond_pass_s = cond_pass_f(instr_r[10:9], flags_r[3], flags_r[2]);
`else
   logic unused_cond_s;
   assign cond_pass_s   = 1'b1;
   assign unused_cond_s = ^instr_r[10:9];
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and the accept / writeback strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      wb_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (instr_valid) begin
               state_nxt_s = ST_ISSUE;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nxt_s = ST_WB;
         end
         ST_WB: begin
            state_nxt_s = ST_IDLE;
            wb_s        = 1'b1;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Host writes are honoured only while idle.
   always_comb begin
      if (wr_en && (state_r == ST_IDLE)) begin
         host_wr_s = 1'b1;
      end else begin
         host_wr_s = 1'b0;
      end
   end

   // Ready is registered from the next state, so it is high exactly in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_ready_r <= 1'b1;
      end else begin
         instr_ready_r <= (state_nxt_s == ST_IDLE);
      end
   end

   // Instruction latch, loaded at the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_r <= 11'd0;
      end else if (accept_s) begin
         instr_r <= instr;
      end else begin
         instr_r <= instr_r;
      end
   end

   // Register file. Host writes and writeback live in different states, so they never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {W{1'b0}};
         end
      end else if (host_wr_s) begin
         regs_r[wr_addr] <= wr_data;
      end else if (wb_s && cond_pass_s) begin
         regs_r[rd_s] <= alu_out;
      end
   end

   // Operand and control-code issue. Operands are captured here, so rd may alias rs1/rs2.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_r    <= {W{1'b0}};
         alu_b_r    <= {W{1'b0}};
         alu_cntl_r <= 3'b000;
      end else if (state_r == ST_ISSUE) begin
         alu_a_r    <= regs_r[rs1_s];
         alu_b_r    <= regs_r[rs2_s];
         alu_cntl_r <= op_s;
      end else begin
         alu_a_r    <= alu_a_r;
         alu_b_r    <= alu_b_r;
         alu_cntl_r <= alu_cntl_r;
      end
   end

   // Result reporting. The ALU value is reported even when the condition fails.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_r <= 1'b0;
         res_data_r  <= {W{1'b0}};
         res_skip_r  <= 1'b0;
      end else if (wb_s) begin
         res_valid_r <= 1'b1;
         res_data_r  <= alu_out;
         res_skip_r  <= ~cond_pass_s;
      end else begin
         res_valid_r <= 1'b0;
         res_data_r  <= res_data_r;
         res_skip_r  <= res_skip_r;
      end
   end

   // Architectural flags {N,Z,C,V}. They update only on an executed instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_r <= 4'b0000;
      end else if (wb_s && cond_pass_s) begin
         flags_r <= {alu_n, alu_z, alu_co, alu_ovf};
      end else begin
         flags_r <= flags_r;
      end
   end

   assign instr_ready = instr_ready_r;
   assign rd_data     = regs_r[rd_addr];
   assign alu_a       = alu_a_r;
   assign alu_b       = alu_b_r;
   assign alu_cntl    = alu_cntl_r;
   assign res_valid   = res_valid_r;
   assign res_data    = res_data_r;
   assign res_skip    = res_skip_r;
   assign flags       = flags_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl. A behavioural ALU answers the
// controller. A reference model of the register file and flags predicts
// each result at the accept edge and queues it. A negedge monitor pops
// the queue on every res_valid.
module tb_alu_seq_ctrl;
   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [10:0]   instr = 11'd0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_addr = 2'd0;
   logic [W-1:0]  wr_data = '0;
   logic [1:0]    rd_addr = 2'd0;
   logic [W-1:0]  rd_data;
   logic [W-1:0]  alu_a, alu_b, alu_out;
   logic [2:0]    alu_cntl;
   logic          alu_co, alu_ovf, alu_n, alu_z;
   logic          res_valid;
   logic [W-1:0]  res_data;
   logic          res_skip;
   logic [3:0]    flags;

   typedef struct {
      logic [W-1:0] data;
      logic         skip;
      logic [3:0]   fl;
      int           acc;
   } exp_t;

   exp_t          sb_q[$];
   logic [W-1:0]  m_r [4];
   logic [3:0]    m_fl;
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;
   int            n_resv = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.W(W), .NREG(4)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cntl(alu_cntl),
      .alu_out(alu_out), .alu_co(alu_co), .alu_ovf(alu_ovf), .alu_n(alu_n), .alu_z(alu_z),
      .res_valid(res_valid), .res_data(res_data), .res_skip(res_skip), .flags(flags)
   );

   // ALU behaviour: returns {n, z, c, v, out}
   function automatic logic [W+3:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] o;
      logic         c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b};      o = s[W-1:0]; c = s[W];
                     v = (a[W-1] == b[W-1]) && (o[W-1] != a[W-1]); end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 1; o = s[W-1:0]; c = s[W];
                     v = (a[W-1] != b[W-1]) && (o[W-1] != a[W-1]); end
         3'd2: begin s = {1'b0, b} + {1'b0, ~a} + 1; o = s[W-1:0]; c = s[W];
                     v = (b[W-1] != a[W-1]) && (o[W-1] != b[W-1]); end
         3'd3: o = a & ~b;
         3'd4: o = a & b;
         3'd5: o = a | b;
         3'd6: o = a ^ b;
         default: o = ~(a ^ b);
      endcase
      return {o[W-1], (o == '0), c, v, o};
   endfunction

   always_comb {alu_n, alu_z, alu_co, alu_ovf, alu_out} = alu_f(alu_cntl, alu_a, alu_b);

   function automatic logic cond_ok(input logic [1:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
      case (c)
         2'b00:   return 1'b1;
         2'b01:   return f[2];
         2'b10:   return ~f[2];
         default: return f[3];
      endcase
`else
      return 1'b1 | (^{c, f} & 1'b0);
`endif
   endfunction

   function automatic logic [10:0] mk(input logic [1:0] cond, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
      return {cond, op, rd, rs1, rs2};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired", tag);
   endtask

   // Reference model. Runs at each edge and predicts the result of every accepted instruction.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int i = 0; i < 4; i++) m_r[i] = '0;
            m_fl = 4'b0000;
            sb_q.delete();
         end else if (instr_ready) begin
            if (wr_en) m_r[wr_addr] = wr_data;
            if (instr_valid) begin
               logic [W+3:0] r;
               logic         p;
               exp_t         e;
               r = alu_f(instr[8:6], m_r[instr[3:2]], m_r[instr[1:0]]);
               p = cond_ok(instr[10:9], m_fl);
               e.data = r[W-1:0];
               e.skip = ~p;
               if (p) begin
                  m_r[instr[5:4]] = r[W-1:0];
                  m_fl = r[W+3:W];
               end
               e.fl  = m_fl;
               e.acc = cyc;
               sb_q.push_back(e);
            end
         end
         cyc++;
      end
   end

   // Result monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            n_resv++;
            if (sb_q.size() == 0) begin
               chk("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("res_data", 32'(res_data), 32'(e.data));
               chk("res_skip", 32'(res_skip), 32'(e.skip));
               chk("flags",    32'(flags),    32'(e.fl));
               chk("latency",  32'(cyc - e.acc), 32'd3);
            end
         end
      end
   end

   task automatic wait_ready();
      int cnt = 0;
      while (instr_ready !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
      if (cnt >= 40) timeout_fail("wait_ready");
   endtask

   task automatic wait_done();
      int cnt = 0;
      while ((sb_q.size() != 0 || instr_ready !== 1'b1) && cnt < 40) begin @(negedge clk); cnt++; end
      if (cnt >= 40) timeout_fail("wait_done");
      @(negedge clk);
   endtask

   task automatic host_wr(input logic [1:0] a, input logic [W-1:0] d);
      wait_ready();
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic issue(input logic [10:0] w);
      wait_ready();
      instr_valid = 1'b1; instr = w;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic check_reg(input logic [1:0] i, input string tag);
      rd_addr = i;
      #1;
      chk(tag, 32'(rd_data), 32'(m_r[i]));
   endtask

   initial begin
      logic [10:0] burst [4];
      logic [W-1:0] r1_save;
      int last, base;

      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0]  burst [4];
      logic [W-1:0] r1_save;
      int           last, base;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      // reset state
      chk("rst_ready",    32'(instr_ready), 32'd1);
      chk("rst_res_valid",32'(res_valid),   32'd0);
      chk("rst_flags",    32'(flags),       32'd0);
      chk("rst_alu_a",    32'(alu_a),       32'd0);
      chk("rst_alu_b",    32'(alu_b),       32'd0);
      chk("rst_alu_cntl", 32'(alu_cntl),    32'd0);
      chk("rst_res_data", 32'(res_data),    32'd0);
      chk("rst_res_skip", 32'(res_skip),    32'd0);
      for (int i = 0; i < 4; i++) check_reg(2'(i), "rst_reg");

      // 3 + 5 -> 8, flags N=1 V=1
      host_wr(2'd0, 4'd3);
      host_wr(2'd1, 4'd5);
      issue(mk(2'b00, 3'd0, 2'd2, 2'd0, 2'd1));
      wait_done();
      check_reg(2'd2, "add_r2");
      chk("add_r2_const", 32'(rd_data), 32'd8);
      chk("add_flags_const", 32'(flags), 32'b1001);

      // 5 - 5 -> 0 with Z, then EQ xor executes
      host_wr(2'd0, 4'd5);
      host_wr(2'd1, 4'd5);
      issue(mk(2'b00, 3'd1, 2'd3, 2'd0, 2'd1));
      wait_done();
      check_reg(2'd3, "sub_r3");
      chk("sub_z", 32'(flags[2]), 32'd1);
      issue(mk(2'b01, 3'd6, 2'd2, 2'd0, 2'd1));
      wait_done();
      check_reg(2'd2, "eq_xor_r2");
      chk("eq_xor_skip", 32'(res_skip), 32'd0);

      // clear Z, then NE and executes, EQ add is skipped
      issue(mk(2'b00, 3'd5, 2'd3, 2'd0, 2'd1));
      wait_done();
      issue(mk(2'b10, 3'd4, 2'd2, 2'd0, 2'd1));
      wait_done();
      check_reg(2'd2, "ne_and_r2");
      issue(mk(2'b01, 3'd0, 2'd3, 2'd0, 2'd1));
      wait_done();
      check_reg(2'd3, "eq_add_r3");
      chk("eq_add_flags", 32'(flags), 32'(m_fl));

      // back-to-back with instr_valid held high
      burst[0] = mk(2'b00, 3'd0, 2'd0, 2'd0, 2'd1);
      burst[1] = mk(2'b00, 3'd2, 2'd1, 2'd0, 2'd1);
      burst[2] = mk(2'b00, 3'd3, 2'd2, 2'd0, 2'd1);
      burst[3] = mk(2'b00, 3'd7, 2'd3, 2'd2, 2'd0);
      base = n_resv;
      last = 0;
      for (int i = 0; i < 4; i++) begin
         instr_valid = 1'b1;
         instr = burst[i];
         wait_ready();
         if (i > 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
         last = cyc;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      wait_done();
      chk("b2b_count", 32'(n_resv - base), 32'd4);
      for (int i = 0; i < 4; i++) check_reg(2'(i), "b2b_reg");

      // host write during ISSUE/WB is ignored
      rd_addr = 2'd1;
      #1 r1_save = rd_data;
      issue(mk(2'b00, 3'd0, 2'd3, 2'd0, 2'd2));
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = r1_save + 4'd1;
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      wait_done();
      check_reg(2'd1, "busy_wr_r1");
      chk("busy_wr_r1_saved", 32'(rd_data), 32'(r1_save));

      // same-cycle host write and accept: ISSUE sees the new value
      wait_ready();
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd7;
      instr_valid = 1'b1; instr = mk(2'b00, 3'd0, 2'd2, 2'd1, 2'd1);
      @(negedge clk);
      wr_en = 1'b0; instr_valid = 1'b0;
      @(negedge clk);
      chk("same_cyc_alu_a", 32'(alu_a), 32'd7);
      wait_done();
      check_reg(2'd2, "same_cyc_r2");

      // reset during WB aborts the instruction
      issue(mk(2'b00, 3'd0, 2'd3, 2'd1, 2'd1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("wbrst_ready", 32'(instr_ready), 32'd1);
      chk("wbrst_flags", 32'(flags),       32'd0);
      chk("wbrst_res_valid", 32'(res_valid), 32'd0);
      for (int i = 0; i < 4; i++) check_reg(2'(i), "wbrst_reg");
      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
